// File: rtl/jpeg_capture_ctrl.sv
// jpeg_capture_ctrl: sequences jpeg_encoder captures with budget-driven QF retry, timeout and abort
module jpeg_capture_ctrl #(
  parameter int SIZE_W = 16,
  parameter int MAX_RETRIES = 3,
  parameter int TIMEOUT_FRAMES = 3
) (
  input  logic              pixel_clock_in,
  input  logic              pixel_reset_in,
  input  logic              capture_req_in,
  input  logic [1:0]        capture_qf_in,
  input  logic              auto_qf_in,
  input  logic [SIZE_W-1:0] size_budget_in,
  input  logic              abort_in,
  output logic              start_capture_out,
  output logic [1:0]        qf_select_out,
  input  logic              frame_valid_in,
  input  logic              data_valid_in,
  input  logic [SIZE_W-1:0] address_in,
  input  logic              image_valid_in,
  output logic              busy_out,
  output logic              done_out,
  output logic [1:0]        status_out,
  output logic [1:0]        final_qf_out,
  output logic [SIZE_W:0]   final_size_out,
  output logic [1:0]        attempts_out
);
  localparam int FC_W = $clog2(TIMEOUT_FRAMES + 2);
  localparam logic [1:0] MAX_A = 2'(MAX_RETRIES);
  typedef enum logic [2:0] {IDLE, ARM, WAIT_CLEAR, CAPTURE, EVAL, DONE} state_t;
  state_t state, state_n;
  logic [1:0] qf, qf_lower;
  logic [SIZE_W-1:0] budget, max_addr;
  logic [FC_W-1:0] frame_cnt;
  logic [SIZE_W:0] size;
  logic auto_q, seen, fv_q, fits, retry, timeout;
  assign qf_lower = qf == 2'd1 ? 2'd0 : qf == 2'd0 ? 2'd3 : 2'd2;
  assign size = seen ? {1'b0, max_addr} + (SIZE_W+1)'(16) : '0;
  assign fits = budget == '0 || size <= {1'b0, budget};
  assign retry = auto_q && qf != 2'd2 && attempts_out < MAX_A;
  assign timeout = frame_cnt > FC_W'(TIMEOUT_FRAMES);
  assign start_capture_out = state == ARM;
  assign done_out = state == DONE;
  assign busy_out = state inside {ARM, WAIT_CLEAR, CAPTURE, EVAL};
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = capture_req_in ? ARM : IDLE;
      ARM:        state_n = abort_in ? DONE : WAIT_CLEAR;
      WAIT_CLEAR: state_n = abort_in ? DONE : image_valid_in ? WAIT_CLEAR : CAPTURE;
      CAPTURE:    state_n = abort_in ? DONE : image_valid_in ? EVAL : timeout ? DONE : CAPTURE;
      EVAL:       state_n = abort_in || fits || !retry ? DONE : ARM;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge pixel_clock_in) begin
    if (pixel_reset_in) begin
      state <= IDLE;
      qf <= '0;
      budget <= '0;
      auto_q <= 1'b0;
      max_addr <= '0;
      frame_cnt <= '0;
      seen <= 1'b0;
      fv_q <= 1'b0;
      qf_select_out <= '0;
      status_out <= '0;
      final_qf_out <= '0;
      final_size_out <= '0;
      attempts_out <= '0;
    end else begin
      state <= state_n;
      fv_q <= frame_valid_in;
      if (state == IDLE && capture_req_in) begin
        qf <= capture_qf_in;
        qf_select_out <= capture_qf_in;
        budget <= size_budget_in;
        auto_q <= auto_qf_in;
        attempts_out <= '0;
        status_out <= '0;
      end
      if (state == ARM) begin
        max_addr <= '0;
        frame_cnt <= '0;
        seen <= 1'b0;
      end
      if (state == CAPTURE && data_valid_in) begin
        max_addr <= address_in > max_addr ? address_in : max_addr;
        seen <= 1'b1;
      end
      if (state == CAPTURE && frame_valid_in && !fv_q)
        frame_cnt <= frame_cnt + FC_W'(1);
      if (state == CAPTURE && !abort_in && !image_valid_in && timeout)
        status_out <= 2'd2;
      if (state == EVAL && !abort_in) begin
        final_size_out <= size;
        final_qf_out <= qf;
        status_out <= fits ? 2'd0 : retry ? status_out : 2'd1;
        if (!fits && retry) begin
          qf <= qf_lower;
          qf_select_out <= qf_lower;
          attempts_out <= attempts_out + 2'd1;
        end
      end
      if (abort_in && state inside {ARM, WAIT_CLEAR, CAPTURE, EVAL})
        status_out <= 2'd3;
    end
  end
endmodule

// File: tb/tb_jpeg_capture_ctrl.sv
// tb_jpeg_capture_ctrl: randomized encoder emulation checked against a per-request outcome model
module tb_jpeg_capture_ctrl;
  localparam int SW = 16;
  logic clk = 0, rst = 1, req = 0, auto_in = 0, abort = 0, fv = 0, dv = 0, iv = 0;
  logic [1:0] qf_in = 0;
  logic [SW-1:0] budget = 0, addr = 0;
  logic start, busy, done;
  logic [1:0] qf_sel, status, fqf, att;
  logic [SW:0] fsize;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  jpeg_capture_ctrl #(.SIZE_W(SW), .MAX_RETRIES(3), .TIMEOUT_FRAMES(3)) dut (
    .pixel_clock_in(clk), .pixel_reset_in(rst), .capture_req_in(req), .capture_qf_in(qf_in),
    .auto_qf_in(auto_in), .size_budget_in(budget), .abort_in(abort), .start_capture_out(start),
    .qf_select_out(qf_sel), .frame_valid_in(fv), .data_valid_in(dv), .address_in(addr),
    .image_valid_in(iv), .busy_out(busy), .done_out(done), .status_out(status),
    .final_qf_out(fqf), .final_size_out(fsize), .attempts_out(att)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, 32'(start), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_qf_sel"}, 32'(qf_sel), 0);
    chk({tag, "_status"}, 32'(status), 0);
    chk({tag, "_fqf"}, 32'(fqf), 0);
    chk({tag, "_fsize"}, 32'(fsize), 0);
    chk({tag, "_att"}, 32'(att), 0);
  endtask
  // Encoder side of one attempt: stale image_valid, data beats whose largest address is s-16, then finish
  task automatic encode(input int s);
    int n, m;
    iv = 1; step(); step();
    iv = 0; step();
    if (s > 0) begin
      n = $urandom_range(1, 5);
      m = $urandom_range(0, n - 1);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          dv = 0; addr = '1; step();
        end
        dv = 1;
        addr = i == m ? SW'(s - 16) : SW'($urandom_range(0, s - 16));
        step();
      end
      dv = 0;
    end else begin
      addr = SW'($urandom); step();
    end
    iv = 1; step(); step();
  endtask
  task automatic run(input int q0, input bit au, input int bud, input int s0, input int s1, input int s2, input int s3);
    int sz[4];
    int lad[4];
    int eq[$];
    int q, a, st, fsz, k;
    sz = '{s0, s1, s2, s3};
    lad = '{1, 0, 3, 2};
    q = q0; a = 0; st = 0; fsz = 0;
    forever begin
      eq.push_back(q);
      fsz = sz[a];
      if (bud == 0 || fsz <= bud) begin st = 0; break; end
      if (au && q != lad[3] && a < 3) begin
        for (int p = 0; p < 3; p++) if (lad[p] == q) begin q = lad[p + 1]; break; end
        a++;
      end else begin st = 1; break; end
    end
    req = 1; qf_in = 2'(q0); auto_in = au; budget = SW'(bud);
    step();
    req = 0; qf_in = 2'($urandom); auto_in = 1'($urandom); budget = SW'($urandom);
    k = 0;
    forever begin
      for (int c = 0; c < 20 && !start && !done; c++) step();
      if (done) break;
      chk("wait_start", 32'(start), 1);
      if (!start || k > 3) break;
      if (k < eq.size()) chk("start_qf", 32'(qf_sel), eq[k]);
      chk("busy_run", 32'(busy), 1);
      encode(sz[k]);
      k++;
    end
    chk("done", 32'(done), 1);
    chk("busy_at_done", 32'(busy), 0);
    chk("starts", k, eq.size());
    chk("status", 32'(status), st);
    chk("final_qf", 32'(fqf), q);
    chk("final_size", 32'(fsize), fsz);
    chk("attempts", 32'(att), a);
    iv = 0;
    step();
    chk("done_pulse", 32'(done), 0);
    chk("status_hold", 32'(status), st);
  endtask
  function automatic int rand_size();
    int r;
    r = $urandom_range(0, 9);
    return r == 0 ? 0 : r == 1 ? 32'h10000 : $urandom_range(1, 4096) * 16;
  endfunction
  initial begin
    step(); step();
    chk_all_zero("reset");
    rst = 0;
    step();
    run(1, 0, 0, 'h1000, 0, 0, 0);
    run(1, 1, 'h2000, 'h5000, 'h3000, 'h1800, 0);
    run(3, 1, 'h0100, 'h4000, 'h4000, 'h4000, 'h4000);
    run(1, 1, 'h1000, 'h1000, 'h4000, 0, 0);
    run(0, 0, 'h0010, 0, 0, 0, 0);
    run(1, 1, 'h0010, 'h5000, 'h5000, 'h5000, 'h5000);
    run(0, 1, 'hFFFF, 'h10000, 'hFFF0, 0, 0);
    // Timeout: four frame starts without completion, with a dropped request in the middle
    req = 1; qf_in = 2; auto_in = 0; budget = 0; step(); req = 0;
    iv = 1; step(); step(); iv = 0; step();
    for (int e = 0; e < 3; e++) begin fv = 1; step(); fv = 0; step(); end
    req = 1; qf_in = 1; step(); req = 0;
    chk("to_busy", 32'(busy), 1);
    chk("to_early", 32'(done), 0);
    fv = 1; step();
    chk("to_4th_edge", 32'(done), 0);
    fv = 0; step();
    chk("to_done", 32'(done), 1);
    chk("to_status", 32'(status), 2);
    step();
    chk("to_no_queue", 32'(busy), 0);
    chk("to_qf_kept", 32'(qf_sel), 2);
    // Abort beats image_valid in the same cycle
    req = 1; qf_in = 0; step(); req = 0;
    iv = 1; step(); step(); iv = 0; step();
    dv = 1; addr = 'h20; step(); dv = 0;
    abort = 1; iv = 1; step();
    chk("ab_done", 32'(done), 1);
    chk("ab_status", 32'(status), 3);
    abort = 0; iv = 0; step();
    chk("ab_one_pulse", 32'(done), 0);
    abort = 1; step(); abort = 0;
    chk("ab_idle_busy", 32'(busy), 0);
    chk("ab_idle_status", 32'(status), 3);
    // Reset in WAIT_CLEAR
    req = 1; qf_in = 3; step(); req = 0;
    chk("rs_qf", 32'(qf_sel), 3);
    iv = 1; step();
    chk("rs_busy", 32'(busy), 1);
    rst = 1; step();
    chk_all_zero("rs");
    rst = 0; iv = 0;
    for (int c = 0; c < 3; c++) begin step(); chk("rs_no_done", 32'(done), 0); end
    for (int t = 0; t < 40; t++) begin
      int s0, b;
      s0 = rand_size();
      b = $urandom_range(0, 3);
      b = b == 0 ? 0 : (b == 1 && s0 > 0 && s0 <= 'hFFFF) ? s0 : $urandom_range(0, 'hFFFF);
      run($urandom_range(0, 3), 1'($urandom), b, s0, rand_size(), rand_size(), rand_size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
